cgol_seed_loader: RTL and testbench

//  Upstream of the current-state register file: loads a new 8x8 seed pattern,
//  one row per transfer, from an external byte source over a valid/ready handshake.

---
 rtl/cgol_seed_loader_pkg.sv | 20 ++
 rtl/cgol_seed_loader_if.sv | 31 +++
 rtl/cgol_seed_loader_row_buf.sv | 65 ++++++
 rtl/cgol_seed_loader.sv | 76 +++++++
 tb/tb_cgol_seed_loader.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cgol_seed_loader_pkg.sv
// Shared constants and state encoding for the seed loader that fills the
// 8x8 current-state register file one row per transfer.
package cgol_pkg;

  localparam int WIDTH   = 8;
  localparam int REGBITS = 3;
  localparam int ROWS    = 2 ** REGBITS;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_LOAD = 2'd1,
    LD_DONE = 2'd2
  } loader_state_t;

  // Row addresses wrap modulo ROWS, so the last row rolls back to row 0.
  function automatic logic [REGBITS-1:0] next_row(input logic [REGBITS-1:0] row);
    return row + 1'b1;
  endfunction

endpackage

// File: rtl/cgol_seed_loader_if.sv
// Bundle of the seed loader's byte-source handshake, regfile write port and
// generation-control outputs.
interface cgol_seed_loader_if;
  import cgol_pkg::*;

  // A row transfers in a cycle where in_valid and in_ready are both high;
  // in_data/in_sof must stay stable while in_valid is high and in_ready low,
  // and in_ready never depends on in_valid.
  logic               load_req;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic               in_sof;
  logic               wr_grant;
  logic               wr_en;
  logic [REGBITS-1:0] wr_addr;
  logic [WIDTH-1:0]   wr_data;
  logic               gen_hold;
  logic               load_done;

  modport master (
    output load_req, in_valid, in_data, in_sof, wr_grant,
    input  in_ready, wr_en, wr_addr, wr_data, gen_hold, load_done
  );

  modport slave (
    input  load_req, in_valid, in_data, in_sof, wr_grant,
    output in_ready, wr_en, wr_addr, wr_data, gen_hold, load_done
  );

endinterface

// File: rtl/cgol_seed_loader_row_buf.sv
// Two-phase enable/reset register and the single-entry row buffer built on it.
// Master captures at the end of ph2, slave releases the value on ph1.
module cgol_flopenr #(
  parameter int W = 1
) (
  input  logic         ph1,
  input  logic         ph2,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] master_d;
  logic [W-1:0] master_q;

  always_comb begin
    master_d = q;
    if (en) master_d = d;
  end

  always_ff @(negedge ph2) begin
    if (reset) master_q <= '0;
    else       master_q <= master_d;
  end

  always_ff @(posedge ph1) begin
    q <= master_q;
  end

endmodule

module cgol_row_buf
  import cgol_pkg::*;
(
  input  logic             ph1,
  input  logic             ph2,
  input  logic             reset,
  input  logic             accept,
  input  logic             drain,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] row_q,
  output logic             buf_full_q
);

  logic full_en;
  logic buf_full_d;

  // A simultaneous accept and drain leaves the entry full with the new row.
  always_comb begin
    full_en    = accept | drain;
    buf_full_d = accept;
  end

  cgol_flopenr #(.W(WIDTH)) u_row (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .en(accept), .d(in_data), .q(row_q)
  );

  cgol_flopenr #(.W(1)) u_full (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .en(full_en), .d(buf_full_d), .q(buf_full_q)
  );

endmodule

// File: rtl/cgol_seed_loader.sv
// Loads an 8x8 seed pattern row by row into the regfile, holding generation
// stepping while it owns the write port and pulsing load_done at the end.
module cgol_seed_loader
  import cgol_pkg::*;
(
  input  logic                ph1,
  input  logic                ph2,
  input  logic                reset,
  cgol_seed_loader_if.slave   bus,
  output loader_state_t       dbg_state
);

  logic [1:0]         state_raw;
  loader_state_t      state_q;
  loader_state_t      state_d;
  logic [REGBITS-1:0] row_idx_q;
  logic [REGBITS-1:0] row_idx_d;
  logic [WIDTH-1:0]   row_q;
  logic               buf_full_q;
  logic               in_load;
  logic               last_row;
  logic               wr_fire;
  logic               in_ready;
  logic               accept;

  always_comb begin
    state_q = loader_state_t'(state_raw);
  end

  always_comb begin
    in_load  = (state_q == LD_LOAD);
    last_row = (row_idx_q == REGBITS'(ROWS - 1));
    wr_fire  = in_load & buf_full_q & bus.wr_grant;
    // Nothing may be accepted alongside the final write: the load ends there.
    in_ready = in_load & (~buf_full_q | bus.wr_grant) & ~(wr_fire & last_row);
    accept   = bus.in_valid & in_ready;

    state_d = state_q;
    case (state_q)
      LD_IDLE: if (bus.load_req) state_d = LD_LOAD;
      LD_LOAD: if (wr_fire && last_row) state_d = LD_DONE;
      LD_DONE: state_d = LD_IDLE;
      default: state_d = LD_IDLE;
    endcase

    // A start-of-frame row restarts addressing even if a write fires now.
    row_idx_d = row_idx_q;
    if (accept && bus.in_sof) row_idx_d = '0;
    else if (wr_fire)         row_idx_d = next_row(row_idx_q);
  end

  cgol_flopenr #(.W(2)) u_state (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .en(1'b1), .d(state_d), .q(state_raw)
  );

  cgol_flopenr #(.W(REGBITS)) u_row_idx (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .en(1'b1), .d(row_idx_d), .q(row_idx_q)
  );

  cgol_row_buf u_buf (
    .ph1(ph1), .ph2(ph2), .reset(reset),
    .accept(accept), .drain(wr_fire), .in_data(bus.in_data),
    .row_q(row_q), .buf_full_q(buf_full_q)
  );

  assign bus.in_ready  = in_ready;
  assign bus.wr_en     = wr_fire;
  assign bus.wr_addr   = row_idx_q;
  assign bus.wr_data   = row_q;
  assign bus.gen_hold  = (state_q == LD_LOAD) | (state_q == LD_DONE);
  assign bus.load_done = (state_q == LD_DONE);
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cgol_seed_loader.sv
// Directed bench for the seed loader: cycle tables for the steady-state flows
// and hand-written sequences for sof restart, mid-load reset and back-to-back loads.
module tb_cgol_seed_loader;
  import cgol_pkg::*;

  logic          ph1;
  logic          ph2;
  logic          reset;
  loader_state_t dbg_state;

  cgol_seed_loader_if bus();

  cgol_seed_loader dut (
    .ph1(ph1), .ph2(ph2), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  // Clock / reset: 40-unit cycle, ph1 high then ph2 high, never overlapping.
  initial begin
    ph1 = 1'b0;
    ph2 = 1'b0;
    #5;
    forever begin
      ph1 = 1'b1; #10;
      ph1 = 1'b0; #10;
      ph2 = 1'b1; #10;
      ph2 = 1'b0; #10;
    end
  end

  initial begin
    #(40 * 4000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int checks   = 0;
  int failures = 0;
  int done_cnt = 0;

  logic [REGBITS+WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0]         tx_data[$];
  logic                     tx_sof[$];
  logic [WIDTH-1:0]         mem[ROWS];

  // Regfile model: the write lands in ph2 of the cycle wr_en is high.
  always @(negedge ph2) begin
    if (bus.wr_en === 1'b1) mem[bus.wr_addr] <= bus.wr_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Driver: new inputs 2 units after ph1 rises, outputs settled 3 units later.
  task automatic drive(input logic rst, input logic lr, input logic v, input logic s,
                       input logic g, input logic [WIDTH-1:0] d);
    @(posedge ph1);
    #2;
    reset        = rst;
    bus.load_req = lr;
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.wr_grant = g;
    bus.in_data  = d;
    #3;
  endtask

  // One cycle with the write scoreboard and load_done counter attached.
  task automatic tick(input logic rst, input logic lr, input logic v, input logic s,
                      input logic g, input logic [WIDTH-1:0] d, output logic rdy);
    drive(rst, lr, v, s, g, d);
    rdy = bus.in_ready;
    if (bus.load_done === 1'b1) done_cnt++;
    if (bus.wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got addr %0d data %0h expected no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        chk("write_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end
    end
  endtask

  task automatic stream(input logic lr, input logic g);
    int   i = 0;
    int   budget = 0;
    logic rdy;
    while (i < tx_data.size() && budget < 200) begin
      tick(1'b0, lr, 1'b1, tx_sof[i], g, tx_data[i], rdy);
      if (rdy) i++;
      budget++;
    end
    chk("stream_rows_accepted", i, tx_data.size());
    tx_data.delete();
    tx_sof.delete();
  endtask

  task automatic wait_done(input logic lr);
    int   n = 0;
    int   start = done_cnt;
    logic rdy;
    while (done_cnt == start && n < 12) begin
      tick(1'b0, lr, 1'b0, 1'b0, 1'b1, '0, rdy);
      n++;
    end
    chk("load_done_seen", done_cnt - start, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  bus.in_ready,  0);
    chk({tag, "_wr_en"},     bus.wr_en,     0);
    chk({tag, "_wr_addr"},   bus.wr_addr,   0);
    chk({tag, "_wr_data"},   bus.wr_data,   0);
    chk({tag, "_gen_hold"},  bus.gen_hold,  0);
    chk({tag, "_load_done"}, bus.load_done, 0);
    chk({tag, "_state"},     dbg_state,     LD_IDLE);
  endtask

  typedef struct {
    logic               lr, v, s, g;
    logic [WIDTH-1:0]   d;
    logic               e_rdy, e_wr;
    logic [REGBITS-1:0] e_addr;
    logic [WIDTH-1:0]   e_data;
    logic               e_hold, e_done;
    int                 tag;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic lr, input logic v, input logic s, input logic g,
                              input logic [WIDTH-1:0] d, input logic er, input logic ew,
                              input logic [REGBITS-1:0] ea, input logic [WIDTH-1:0] ed,
                              input logic eh, input logic edn, input int tag);
    vec_t t;
    t.lr = lr; t.v = v; t.s = s; t.g = g; t.d = d;
    t.e_rdy = er; t.e_wr = ew; t.e_addr = ea; t.e_data = ed;
    t.e_hold = eh; t.e_done = edn; t.tag = tag;
    vecs.push_back(t);
  endfunction

  initial begin
    logic             rdy;
    logic [WIDTH-1:0] one;
    one          = 8'h01;
    reset        = 1'b1;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.wr_grant = 1'b0;
    bus.in_data  = '0;

    // Tables: idle with traffic, full-rate load, grant toggling load.
    for (int k = 0; k < 4; k++)
      add(1'b0, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 6);

    add(1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1);
    add(1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 1);
    for (int k = 2; k <= 8; k++)
      add(1'b0, 1'b1, 1'b0, 1'b1, one << (k - 1), 1'b1, 1'b1,
          REGBITS'(k - 2), one << (k - 2), 1'b1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80, 1'b1, 1'b0, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 1);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1);

    add(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 2);
    for (int i = 0; i <= 16; i++) begin
      logic even;
      even = ((i % 2) == 0);
      add(1'b0, 1'b1, (i == 0), even, one << ((i + 1) / 2),
          even && (i != 16), even && (i >= 2),
          (i >= 2) ? REGBITS'((i - 2) / 2) : 3'd0,
          (i >= 2) ? (one << ((i - 2) / 2)) : 8'h00, 1'b1, 1'b0, 2);
    end
    add(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b1, 2);
    add(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 2);

    // Reset state.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check_reset_outputs("reset");

    foreach (vecs[n]) begin
      drive(1'b0, vecs[n].lr, vecs[n].v, vecs[n].s, vecs[n].g, vecs[n].d);
      chk($sformatf("v%0d_t%0d_in_ready", n, vecs[n].tag), bus.in_ready, vecs[n].e_rdy);
      chk($sformatf("v%0d_t%0d_wr_en", n, vecs[n].tag), bus.wr_en, vecs[n].e_wr);
      if (vecs[n].e_wr) begin
        chk($sformatf("v%0d_t%0d_wr_addr", n, vecs[n].tag), bus.wr_addr, vecs[n].e_addr);
        chk($sformatf("v%0d_t%0d_wr_data", n, vecs[n].tag), bus.wr_data, vecs[n].e_data);
      end
      chk($sformatf("v%0d_t%0d_gen_hold", n, vecs[n].tag), bus.gen_hold, vecs[n].e_hold);
      chk($sformatf("v%0d_t%0d_load_done", n, vecs[n].tag), bus.load_done, vecs[n].e_done);
    end
    for (int k = 0; k < ROWS; k++)
      chk($sformatf("t2_mem%0d", k), mem[k], one << k);

    // sof restart after three rows.
    exp_q.delete();
    done_cnt = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    tx_data = '{8'h01, 8'h02, 8'h04, 8'hAA};
    tx_sof  = '{1'b1, 1'b0, 1'b0, 1'b1};
    exp_q   = '{{3'd0, 8'h01}, {3'd1, 8'h02}, {3'd2, 8'h04}, {3'd0, 8'hAA}};
    for (int k = 1; k < ROWS; k++) begin
      tx_data.push_back(8'hB0 + 8'(k));
      tx_sof.push_back(1'b0);
      exp_q.push_back({REGBITS'(k), 8'hB0 + 8'(k)});
    end
    stream(1'b0, 1'b1);
    wait_done(1'b0);
    chk("t3_writes_left", exp_q.size(), 0);
    chk("t3_mem0", mem[0], 8'hAA);
    chk("t3_mem2", mem[2], 8'hB2);
    chk("t3_mem7", mem[7], 8'hB7);

    // Reset after five rows written, then a clean reload from row 0.
    done_cnt = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    for (int k = 0; k < 5; k++) begin
      tx_data.push_back(8'h21 + 8'(k));
      tx_sof.push_back(k == 0);
      exp_q.push_back({REGBITS'(k), 8'h21 + 8'(k)});
    end
    stream(1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0, rdy);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h26, rdy);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0);
    check_reset_outputs("t4_after_reset");
    chk("t4_writes_left", exp_q.size(), 0);
    chk("t4_no_done", done_cnt, 0);
    chk("t4_mem4_kept", mem[4], 8'h25);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    for (int k = 0; k < ROWS; k++) begin
      tx_data.push_back(8'h31 + 8'(k));
      tx_sof.push_back(1'b0);
      exp_q.push_back({REGBITS'(k), 8'h31 + 8'(k)});
    end
    stream(1'b0, 1'b1);
    wait_done(1'b0);
    chk("t4_reload_writes_left", exp_q.size(), 0);

    // load_req held high through DONE: one IDLE cycle, then a fresh LOAD.
    done_cnt = 0;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    for (int k = 0; k < ROWS; k++) begin
      tx_data.push_back(8'h41 + 8'(k));
      tx_sof.push_back(k == 0);
      exp_q.push_back({REGBITS'(k), 8'h41 + 8'(k)});
    end
    stream(1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    chk("t5_done_pulse", bus.load_done, 1);
    chk("t5_done_hold", bus.gen_hold, 1);
    chk("t5_done_state", dbg_state, LD_DONE);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    chk("t5_idle_state", dbg_state, LD_IDLE);
    chk("t5_idle_hold", bus.gen_hold, 0);
    chk("t5_idle_done", bus.load_done, 0);
    chk("t5_idle_ready", bus.in_ready, 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    chk("t5_reload_state", dbg_state, LD_LOAD);
    chk("t5_reload_hold", bus.gen_hold, 1);
    chk("t5_reload_ready", bus.in_ready, 1);
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    chk("t5_single_done", done_cnt, 1);
    for (int k = 0; k < ROWS; k++) begin
      tx_data.push_back(8'h51 + 8'(k));
      tx_sof.push_back(1'b0);
      exp_q.push_back({REGBITS'(k), 8'h51 + 8'(k)});
    end
    stream(1'b1, 1'b1);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0, rdy);
    chk("t5_second_done", done_cnt, 2);
    chk("t5_writes_left", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
